// File: rtl/common_pseudo_lru_victim_alloc_if.sv
// Handshake bundle between the victim-allocation controller, its requesters,
// the refill engine and the pseudo-LRU tracker write port.
interface common_pseudo_lru_victim_alloc_if #(
    parameter int SUBJECT_COUNT_LOG2 = 1
);
    localparam int L = SUBJECT_COUNT_LOG2;
    localparam int W = 1 << SUBJECT_COUNT_LOG2;

    logic         hit_valid;
    logic [L-1:0] hit_way;
    logic         inval_valid;
    logic [L-1:0] inval_way;
    logic         alloc_req;
    logic         alloc_ready;
    logic         fill_start;
    logic [L-1:0] fill_way;
    logic         fill_done;
    logic         fill_abort;
    logic         alloc_done;
    logic [L-1:0] alloc_way;
    logic [L-1:0] lru_qaddr;
    logic [L-1:0] lru_waddr;
    logic         lru_wen;
    logic [W-1:0] way_valid;
    logic         busy;

    // master: the surrounding cache pipeline / refill engine / tracker
    modport master (
        output hit_valid, hit_way, inval_valid, inval_way, alloc_req,
               fill_done, fill_abort, lru_qaddr,
        input  alloc_ready, fill_start, fill_way, alloc_done, alloc_way,
               lru_waddr, lru_wen, way_valid, busy
    );

    // slave: the allocation controller
    modport slave (
        input  hit_valid, hit_way, inval_valid, inval_way, alloc_req,
               fill_done, fill_abort, lru_qaddr,
        output alloc_ready, fill_start, fill_way, alloc_done, alloc_way,
               lru_waddr, lru_wen, way_valid, busy
    );
endinterface

// File: rtl/common_pseudo_lru_victim_alloc.sv
// Victim allocator feeding a pseudo-LRU tracker: merges hit touches and refill commits
// into one LRU write per cycle, runs start/done/abort refill handshake, tracks way valids.
// Latency: accept N, fill_start N+1, commit N+3; alloc_ready held low while an allocation is in flight.
// Optional COMMON_PSEUDO_LRU_VICTIM_INVALID_FIRST_EN: prefer the lowest invalid way as victim.
module common_pseudo_lru_victim_alloc #(
    parameter int SUBJECT_COUNT_LOG2 = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    common_pseudo_lru_victim_alloc_if.slave bus
);
    localparam int L = SUBJECT_COUNT_LOG2;
    localparam int W = 1 << SUBJECT_COUNT_LOG2;

    typedef enum logic [1:0] {IDLE, START, FILL, COMMIT} state_t;

    state_t       state, state_nxt;
    logic [L-1:0] victim_r, victim_sel;
    logic         accept, commit_now, abort_now, hit_ok;
    logic         pend_vld;
    logic [L-1:0] pend_way;
    logic [W-1:0] way_valid_q, valid_nxt;

    assign bus.alloc_ready = (state == IDLE) && !reset;
    assign accept          = bus.alloc_req && bus.alloc_ready;
    assign bus.way_valid   = way_valid_q;
    // a touch on the way being refilled would be stale once the fill lands
    assign hit_ok = bus.hit_valid && !((state != IDLE) && (bus.hit_way == victim_r));

`ifdef COMMON_PSEUDO_LRU_VICTIM_INVALID_FIRST_EN
    always_comb begin
        victim_sel = bus.lru_qaddr;
        for (int i = W - 1; i >= 0; i--) begin
            if (!way_valid_q[i]) victim_sel = L'(i);
        end
    end
`else
    assign victim_sel = bus.lru_qaddr;
`endif

    always_comb begin
        state_nxt  = state;
        commit_now = 1'b0;
        abort_now  = 1'b0;
        case (state)
            IDLE:   if (accept) state_nxt = START;
            START:  state_nxt = FILL;
            FILL: begin
                if (bus.fill_abort) begin
                    abort_now = 1'b1;
                    state_nxt = IDLE;
                end else if (bus.fill_done) begin
                    commit_now = 1'b1;
                    state_nxt  = COMMIT;
                end
            end
            COMMIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // the set is applied entering COMMIT and re-asserted during it, so an
    // invalidate of the committed way in either cycle loses to the set
    always_comb begin
        valid_nxt = way_valid_q;
        if (bus.inval_valid) valid_nxt[bus.inval_way] = 1'b0;
        if (abort_now) valid_nxt[victim_r] = 1'b0;
        if (commit_now || state == COMMIT) valid_nxt[victim_r] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            victim_r       <= '0;
            pend_vld       <= 1'b0;
            pend_way       <= '0;
            way_valid_q    <= '0;
            bus.fill_start <= 1'b0;
            bus.fill_way   <= '0;
            bus.alloc_done <= 1'b0;
            bus.alloc_way  <= '0;
            bus.lru_wen    <= 1'b0;
            bus.lru_waddr  <= '0;
            bus.busy       <= 1'b0;
        end else begin
            state          <= state_nxt;
            way_valid_q    <= valid_nxt;
            bus.busy       <= (state_nxt != IDLE);
            bus.fill_start <= accept;
            bus.alloc_done <= commit_now;
            if (accept) begin
                victim_r     <= victim_sel;
                bus.fill_way <= victim_sel;
            end
            if (commit_now) bus.alloc_way <= victim_r;

            // commit owns the write slot; a fresh hit beats an older pending touch
            if (commit_now) begin
                bus.lru_wen   <= 1'b1;
                bus.lru_waddr <= victim_r;
                if (hit_ok) begin
                    pend_vld <= 1'b1;
                    pend_way <= bus.hit_way;
                end
            end else if (hit_ok) begin
                bus.lru_wen   <= 1'b1;
                bus.lru_waddr <= bus.hit_way;
                pend_vld      <= 1'b0;
            end else if (pend_vld) begin
                bus.lru_wen   <= 1'b1;
                bus.lru_waddr <= pend_way;
                pend_vld      <= 1'b0;
            end else begin
                bus.lru_wen <= 1'b0;
            end
        end
    end
endmodule

// File: doc/common_pseudo_lru_victim_alloc.md
# common_pseudo_lru_victim_alloc

Victim-allocation controller that drives a binary-addressed pseudo-LRU replacement tracker. Merges hit touches and miss refills into one LRU write per cycle. Captures the tracker's victim way and runs a start/done/abort handshake with the refill engine. Keeps per-way valid bits. Sits directly upstream of the pseudo-LRU: its `lru_waddr`/`lru_wen` feed the tracker's write port, and it consumes the tracker's `qaddr`.

## Interface
- `SUBJECT_COUNT_LOG2`, default 1: log2 of way count; W = 1 << SUBJECT_COUNT_LOG2 ways, way index width L = SUBJECT_COUNT_LOG2.
- `clk` in 1: the single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `hit_valid` in 1: hit touch request.
- `hit_way` in L: way hit.
- `inval_valid` in 1: invalidate request.
- `inval_way` in L: way to invalidate.
- `alloc_req` in 1: miss needs a victim.
- `alloc_ready` out 1: request accepted when `alloc_req & alloc_ready`.
- `fill_start` out 1: one-cycle refill start pulse.
- `fill_way` out L: way being refilled.
- `fill_done` in 1: refill completed.
- `fill_abort` in 1: refill cancelled.
- `alloc_done` out 1: one-cycle commit pulse.
- `alloc_way` out L: committed way.
- `lru_qaddr` in L: current LRU victim from tracker.
- `lru_waddr` out L: tracker write address.
- `lru_wen` out 1: tracker write enable.
- `way_valid` out W: per-way valid bits.
- `busy` out 1: allocation in flight (state != IDLE).

## Operation
- FSM states: IDLE, START, FILL, COMMIT.
  - IDLE: `alloc_ready` = 1. On accept, register the victim into `victim_r`; go to START.
  - START: `fill_start` = 1 and `fill_way` = `victim_r`; go to FILL. `fill_done`/`fill_abort` in START are ignored.
  - FILL: wait. `fill_abort` takes priority over `fill_done` and returns to IDLE with no LRU write; `way_valid[victim_r]` is cleared. `fill_done` goes to COMMIT.
  - COMMIT: `alloc_done` = 1 and `alloc_way` = `victim_r`; set `way_valid[victim_r]`; issue the LRU write for `victim_r`; return to IDLE.
- Hit touches:
  - `hit_valid` at cycle N produces `lru_wen` = 1 and `lru_waddr` = `hit_way` at N+1.
  - A COMMIT write owns its cycle. A hit touch that collides with it is held in a one-entry pending register and issued the next cycle.
  - A new hit arriving while pending is occupied overwrites pending; the older touch is dropped, which is acceptable for pseudo-LRU.
  - Hits on `victim_r` while busy are discarded.
- Invalidation: `inval_valid` clears `way_valid[inval_way]` next cycle. If an invalidation and a COMMIT set target the same way in the same cycle, the set wins.
- Valid bits are never set by hits; only COMMIT sets them.
- Reset mid-operation: FSM returns to IDLE; the pending touch and all valid bits are cleared; no `lru_wen` is issued.

## Timing
- Reset values (while `reset` = 1 and the cycle after): all outputs 0, including `alloc_ready` = 0 during reset. `alloc_ready` = 1 from the first cycle after `reset` deasserts.
- All outputs are registered except `alloc_ready`, which is decoded from the state register.
- Accept at N; `fill_start` at N+1; earliest `fill_done` at N+2; `alloc_done` and `lru_wen` at N+3; `alloc_ready` again at N+4.
- Back-to-back allocations: at most one per 4 cycles.
- At most one `lru_wen` per cycle; `lru_waddr` holds its last value when `lru_wen` = 0.

## Configuration
- `COMMON_PSEUDO_LRU_VICTIM_INVALID_FIRST_EN` defined: on accept, the victim is the lowest-index way with `way_valid` = 0. `lru_qaddr` is used only when all ways are valid.
- Not defined: the victim is always `lru_qaddr`; `way_valid` is still tracked and output.

## Test plan
- Reset, then W=4, `lru_qaddr`=2, macro off: `alloc_req` at N -> `fill_start` with `fill_way`=2 at N+1. `fill_done` at N+2 -> `alloc_done` with `alloc_way`=2, `lru_wen` with `lru_waddr`=2, and `way_valid`=4'b0100 at N+3.
- Macro on, `way_valid`=4'b0011, `lru_qaddr`=0: alloc -> `fill_way`=2. With `way_valid`=4'b1111: alloc -> `fill_way`=`lru_qaddr`.
- Hit collides with COMMIT: `hit_valid` with `hit_way`=1 in the same cycle as `fill_done` for way 3 -> `lru_waddr`=3 at N+1, then `lru_waddr`=1 at N+2.
- `fill_done` and `fill_abort` asserted together in FILL -> no `alloc_done`, no `lru_wen`, victim valid bit 0, `alloc_ready`=1 next cycle.
- `inval_valid` with `inval_way`=3 in the COMMIT cycle of way 3 -> `way_valid[3]`=1. `inval_valid` with `inval_way`=1 alone -> `way_valid[1]`=0 the next cycle.
- `reset` asserted during FILL -> next cycle state IDLE, all outputs 0, no `lru_wen`.
